serial_addsub: RTL and testbench

- Bit-serial WIDTH-bit two's-complement adder/subtractor built around a single 1-bit add/sub cell.
- Each cycle it feeds one operand bit pair, LSB first, into the cell, with b inverted by the sub control and carry-in from a carry flip-flop.
- Sum bits are shifted into a result register.
- Used in the lab datapath as a low-area ALU alternative to a ripple array of cells; flags feed the status register.

---
 rtl/serial_addsub_pkg.sv | 12 +
 rtl/addsub_bit_cell.sv | 19 +
 rtl/serial_addsub.sv | 138 +++++++++++++
 tb/tb_serial_addsub.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/addsub_bit_cell.sv
// Single 1-bit add/sub cell: b is inverted by ctl before entering a full adder.
module addsub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ctl,
    input  logic ci,
    output logic s,
    output logic co
);

    logic bx;

    always_comb begin
        bx = b ^ ctl;
        s  = a ^ bx ^ ci;
        co = (a & bx) | (ci & (a ^ bx));
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit two's-complement adder/subtractor, one operand bit per cycle, LSB first.
// Optional zero-result flag enabled by defining SERIAL_ADDSUB_ZERO_FLAG_EN.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             sub_r;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             co;
    logic             c_msb;
    logic             accept;
    logic             last_bit;

    addsub_bit_cell u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .ctl (sub_r),
        .ci  (carry),
        .s   (s),
        .co  (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        c_msb     = carry;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Carry FF seeded with sub supplies the +1 of the two's-complement negation of b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sub_r    <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            sub_r <= sub;
            carry <= sub;
            cnt   <= '0;
        end else if (busy) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            result <= {s, result[WIDTH-1:1]};
            carry  <= co;
            if (last_bit) begin
                cout     <= co;
                overflow <= c_msb ^ co;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic zero_acc;

    // Running OR of sum bits; the final bit is folded in on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            zero_acc <= 1'b0;
            zero     <= 1'b0;
        end else if (busy) begin
            zero_acc <= zero_acc | s;
            if (last_bit) begin
                zero <= ~(zero_acc | s);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: table vectors, corner sequences and randomized ops vs a model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    int checks;
    int errors;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_r;
        logic         exp_c;
        logic         exp_v;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] r, output logic c, output logic v);
        int ua, ub, sa, sb, st;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            r  = W'(ua - ub);
            c  = (ua >= ub);
            st = sa - sb;
        end else begin
            r  = W'(ua + ub);
            c  = ((ua + ub) >= (1 << W));
            st = sa + sb;
        end
        v = (st > ((1 << (W - 1)) - 1)) || (st < -(1 << (W - 1)));
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          output int lat);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        sub   = ts;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
        sub   = ~ts;
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done) chk("busy_during_run", 32'(busy), 32'd1);
        end
    endtask

    task automatic verify_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic ts, input logic [W-1:0] er, input logic ec, input logic ev);
        int lat;
        logic [W-1:0] held;
        run_op(ta, tb_v, ts, lat);
        chk({name, "_latency"}, 32'(lat), 32'(W));
        chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({name, "_result"}, 32'(result), 32'(er));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
        chk({name, "_overflow"}, 32'(overflow), 32'(ev));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        chk({name, "_zero"}, 32'(zero), 32'(er == '0));
`endif
        held = result;
        @(posedge clk);
        #1;
        chk({name, "_done_single"}, 32'(done), 32'd0);
        chk({name, "_result_hold"}, 32'(result), 32'(held));
    endtask

    initial begin
        int ndone, nbusy, gap, res_at_done;
        logic [W-1:0] ra, rb, er;
        logic rs, ec, ev;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        a      = '0;
        b      = '0;

        vecs[0] = '{8'd5,    8'd3,    1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'd100,  8'd50,   1'b0, 8'h96, 1'b0, 1'b1};
        vecs[2] = '{8'd3,    8'd5,    1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h80,   8'h01,   1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'd7,    8'd7,    1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'd1,    8'd0,    1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'hFF,   8'h01,   1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h7F,   8'h01,   1'b0, 8'h80, 1'b0, 1'b1};

        #23;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        chk("reset_zero", 32'(zero), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            verify_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
                      vecs[i].exp_r, vecs[i].exp_c, vecs[i].exp_v);
        end

        // Start pulsed mid-RUN must be ignored.
        @(negedge clk);
        a = 8'd1; b = 8'd1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        res_at_done = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                res_at_done = int'(result);
            end
        end
        chk("ignore_start_done_count", 32'(ndone), 32'd1);
        chk("ignore_start_result", 32'(res_at_done), 32'h02);

        // Reset asserted mid-RUN aborts immediately with no later done.
        @(negedge clk);
        a = 8'h55; b = 8'h33; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_no_busy", 32'(nbusy), 32'd0);

        // Start held high: back-to-back operations every W+2 cycles.
        @(negedge clk);
        a = 8'd9; b = 8'd4; sub = 1'b0; start = 1'b1;
        gap = 0;
        while (!done && gap < 40) begin
            @(posedge clk);
            #1;
            gap++;
        end
        chk("held_start_first_done", 32'(done), 32'd1);
        chk("held_start_result", 32'(result), 32'd13);
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
            if (done && busy) chk("done_busy_exclusive", 32'd1, 32'd0);
        end while (!done && gap < 40);
        chk("held_start_period", 32'(gap), 32'(W + 2));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, er, ec, ev);
            verify_op($sformatf("rand%0d", i), ra, rb, rs, er, ec, ev);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
